// File: rtl/fir_mac_mc.sv
// fir_mac_mc: multi-channel, time-multiplexed FIR filter with one shared MAC.
// Each channel keeps its own delay line; all channels share one run-time
// loadable coefficient bank. Ready/valid handshakes on input and output.
// Define FIR_SATURATE_EN to clamp the scaled result to the DATA_W range;
// without it the result wraps to its low DATA_W bits.
module fir_mac_mc #(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter int TAPS     = 30,
   parameter int CHANNELS = 2,
   parameter int ACC_W    = DATA_W + COEF_W + $clog2(TAPS),
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter int ADDR_W   = $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH_W-1:0]          in_channel,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic [4:0]               right_shift,
   input  logic                     coef_we,
   input  logic [ADDR_W-1:0]        coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_channel,
   output logic signed [DATA_W-1:0] data_out
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [CH_W:0]     CH_LIM   = (CH_W+1)'(CHANNELS);
   localparam logic [ADDR_W:0]   TAP_LIM  = (ADDR_W+1)'(TAPS);
   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS-1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      SCALE = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t                     state;
   logic                       drain;
   logic [ADDR_W-1:0]          tap;
   logic [CH_W-1:0]            ch_q;
   logic [4:0]                 shift_q;
   logic signed [ACC_W-1:0]    acc;
   logic signed [PROD_W-1:0]   prod_q;
   logic signed [DATA_W-1:0]   dly  [CHANNELS][TAPS];
   logic signed [COEF_W-1:0]   coef [TAPS];

   logic                       ch_ok;
   logic                       addr_ok;
   logic signed [ACC_W-1:0]    scaled;
   logic signed [DATA_W-1:0]   reduced;

   assign in_ready = (state == IDLE);
   assign ch_ok    = ({1'b0, in_channel} < CH_LIM);
   assign addr_ok  = ({1'b0, coef_addr} < TAP_LIM);

`ifdef FIR_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

   // Scale the final accumulator and reduce it to the output width.
   always_comb begin
      scaled  = acc >>> shift_q;
`ifdef FIR_SATURATE_EN
      if (scaled > SAT_MAX) begin
         reduced = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (scaled < SAT_MIN) begin
         reduced = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         reduced = scaled[DATA_W-1:0];
      end
`else
      reduced = scaled[DATA_W-1:0];
`endif
   end

   // Coefficient bank: writes land only while idle and within range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned t = 0; t < TAPS; t++) begin
            coef[t] <= '0;
         end
      end else if (coef_we && (state == IDLE) && addr_ok) begin
         coef[coef_addr] <= coef_data;
      end
   end

   // Control FSM plus delay lines, MAC datapath and registered outputs.
   // The product is registered before accumulation, so the first SCALE
   // cycle drains the last tap's product into acc before scaling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         drain       <= 1'b0;
         tap         <= '0;
         ch_q        <= '0;
         shift_q     <= '0;
         acc         <= '0;
         prod_q      <= '0;
         out_valid   <= 1'b0;
         out_channel <= '0;
         data_out    <= '0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned t = 0; t < TAPS; t++) begin
               dly[c][t] <= '0;
            end
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && ch_ok) begin
                  for (int unsigned t = TAPS-1; t > 0; t--) begin
                     dly[in_channel][t] <= dly[in_channel][t-1];
                  end
                  dly[in_channel][0] <= data_in;
                  ch_q    <= in_channel;
                  shift_q <= right_shift;
                  acc     <= '0;
                  prod_q  <= '0;
                  tap     <= '0;
                  drain   <= 1'b0;
                  state   <= MAC;
               end
            end
            MAC: begin
               prod_q <= PROD_W'(dly[ch_q][tap]) * PROD_W'(coef[tap]);
               acc    <= acc + ACC_W'(prod_q);
               if (tap == LAST_TAP) begin
                  state <= SCALE;
               end else begin
                  tap <= tap + ADDR_W'(1);
               end
            end
            SCALE: begin
               if (!drain) begin
                  acc   <= acc + ACC_W'(prod_q);
                  drain <= 1'b1;
               end else begin
                  data_out    <= reduced;
                  out_channel <= ch_q;
                  out_valid   <= 1'b1;
                  state       <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_mc.sv
// Self-checking bench for fir_mac_mc (TAPS=4, CHANNELS=2). A behavioural
// model computes each expected result when a sample is accepted and pushes
// it to a scoreboard queue; results are popped and compared on out_valid.
`timescale 1ns/1ps
module tb_fir_mac_mc;
   localparam int DATA_W   = 16;
   localparam int COEF_W   = 16;
   localparam int TAPS     = 4;
   localparam int CHANNELS = 2;
   localparam int CH_W     = 1;
   localparam int ADDR_W   = 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b1;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic [CH_W-1:0]          in_channel = '0;
   logic signed [DATA_W-1:0] data_in = '0;
   logic [4:0]               right_shift = '0;
   logic                     coef_we = 1'b0;
   logic [ADDR_W-1:0]        coef_addr = '0;
   logic signed [COEF_W-1:0] coef_data = '0;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   logic [CH_W-1:0]          out_channel;
   logic signed [DATA_W-1:0] data_out;

   always #5 clk = ~clk;

   fir_mac_mc #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .CHANNELS(CHANNELS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel),
      .data_in(data_in), .right_shift(right_shift),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_channel(out_channel), .data_out(data_out)
   );

   typedef struct {
      int                       ch;
      logic signed [DATA_W-1:0] d;
   } exp_t;

   exp_t sb[$];
   int   mdly [CHANNELS][TAPS];
   int   mcoef [TAPS];
   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [DATA_W-1:0] model_out(input int ch, input int sh);
      longint acc;
      longint s;
      acc = 0;
      for (int k = 0; k < TAPS; k++) begin
         acc += longint'(mdly[ch][k]) * longint'(mcoef[k]);
      end
      s = acc >>> sh;
`ifdef FIR_SATURATE_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`endif
      return s[DATA_W-1:0];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CHANNELS; c++)
         for (int k = 0; k < TAPS; k++) mdly[c][k] = 0;
      for (int k = 0; k < TAPS; k++) mcoef[k] = 0;
   endtask

   task automatic load_coef(input int a, input int v);
      coef_we   = 1'b1;
      coef_addr = ADDR_W'(a);
      coef_data = COEF_W'(v);
      @(posedge clk); #1;
      coef_we   = 1'b0;
      mcoef[a]  = v;
   endtask

   task automatic send(input int ch, input int x, input int sh);
      int   n;
      exp_t e;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_idle", in_ready, 1);
      in_valid    = 1'b1;
      in_channel  = CH_W'(ch);
      data_in     = DATA_W'(x);
      right_shift = 5'(sh);
      @(posedge clk); #1;
      in_valid    = 1'b0;
      chk("in_ready_busy", in_ready, 0);
      for (int k = TAPS-1; k > 0; k--) mdly[ch][k] = mdly[ch][k-1];
      mdly[ch][0] = x;
      e.ch = ch;
      e.d  = model_out(ch, sh);
      sb.push_back(e);
   endtask

   task automatic collect(input int exp_lat, input int hold);
      int                       n;
      exp_t                     e;
      logic signed [DATA_W-1:0] d0;
      logic [CH_W-1:0]          c0;
      bit                       stable;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (out_valid !== 1'b1) begin
         chk("out_valid_timeout", out_valid, 1);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (exp_lat >= 0) chk("latency", n, exp_lat);
      if (sb.size() == 0) begin
         chk("unexpected_output", 1, 0);
         return;
      end
      e = sb.pop_front();
      chk("data_out", data_out, e.d);
      chk("out_channel", out_channel, e.ch);
      if (hold > 0) begin
         stable = 1'b1;
         d0 = data_out;
         c0 = out_channel;
         repeat (hold) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || data_out !== d0 ||
                out_channel !== c0 || in_ready !== 1'b0) stable = 1'b0;
         end
         chk("hold_stable", stable, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_return", in_ready, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      model_reset();

      // Reset state
      #2 rst_n = 1'b0;
      #10;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_out_channel", out_channel, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);

      // Coefficients k+1
      for (int k = 0; k < TAPS; k++) load_coef(k, k + 1);

      // Impulse on ch0 with a ch1 sample interleaved for isolation
      send(0, 1000, 0); collect(6, 0);
      send(0, 0, 0);    collect(6, 0);
      send(1, 5, 0);    collect(6, 0);
      repeat (3) begin send(0, 0, 0); collect(6, 0); end

      // Backpressure: hold out_ready low for 10 cycles in OUT
      send(0, 100, 0);  collect(6, 10);
      repeat (4) begin send(0, 0, 0); collect(6, 0); end

      // Coefficient write during MAC is ignored
      send(0, 1000, 0);
      @(posedge clk); #1;
      coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd7;
      @(posedge clk); #1;
      coef_we = 1'b0;
      collect(4, 0);
      repeat (4) begin send(0, 0, 0); collect(6, 0); end

      // Same write in IDLE takes effect
      load_coef(0, 7);
      send(0, 1000, 0); collect(6, 0);
      repeat (4) begin send(0, 0, 0); collect(6, 0); end

      // Overflow: full-scale coefficients and samples
      for (int k = 0; k < TAPS; k++) load_coef(k, 32767);
      repeat (4) begin send(0, 32767, 0); collect(6, 0); end
      out_ready = 1'b1;
      send(0, 32767, 20); collect(6, 0);

      // Reset in the middle of MAC
      send(0, 1000, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_data_out", data_out, 0);
      chk("midrst_in_ready", in_ready, 1);
      void'(sb.pop_back());
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      chk("no_result_after_reset", seen, 0);
      send(0, 1000, 0); collect(6, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fir_mac_mc.md
# fir_mac_mc

Multi-channel, time-multiplexed FIR filter with a single shared multiply-accumulate unit, run-time loadable coefficients, and ready/valid handshakes on both input and output. Each channel has its own delay line; all channels share one coefficient set. The block is the parametrised successor of the fixed-coefficient, single-channel FIR in the audio/DSP datapath, and it sits between the sample source and downstream scaling/playback logic.

## Interface
Parameters:
- `DATA_W`, 16: signed sample width for input and output.
- `COEF_W`, 16: signed coefficient width.
- `TAPS`, 30: filter length, ≥ 2.
- `CHANNELS`, 2: number of independent delay lines, ≥ 1.
- Derived: `ACC_W` = `DATA_W` + `COEF_W` + `$clog2(TAPS)`, `CH_W` = max(1, `$clog2(CHANNELS)`), `ADDR_W` = `$clog2(TAPS)`.

Ports:
- `clk`, in, 1: sole clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: sample offered.
- `in_ready`, out, 1: high only in IDLE.
- `in_channel`, in, `CH_W`: channel index of the offered sample.
- `data_in`, in, `DATA_W`, signed: sample.
- `right_shift`, in, 5: output arithmetic shift, sampled at accept.
- `coef_we`, in, 1: coefficient write strobe.
- `coef_addr`, in, `ADDR_W`: tap index; 0 multiplies the newest sample.
- `coef_data`, in, `COEF_W`, signed: coefficient value.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: downstream accepts.
- `out_channel`, out, `CH_W`: channel of the result.
- `data_out`, out, `DATA_W`, signed: filtered sample.

## Operation
- Reset (asynchronous, `rst_n` low) clears everything immediately: state goes to IDLE, all delay lines = 0, all coefficients = 0, accumulator = 0, `out_valid`=0, `out_channel`=0, `data_out`=0, and `in_ready`=1 once `rst_n` deasserts.
- States: IDLE → MAC → SCALE → OUT → IDLE.
- IDLE: when `in_valid` and `in_ready` are both high, the block accepts the sample, latches `in_channel` and `right_shift`, shifts the selected channel's delay line (new sample at position 0, the oldest sample dropped), clears the accumulator and tap counter, and moves to MAC. Other channels' delay lines are unchanged.
- Out-of-range `in_channel` (≥ `CHANNELS`): the sample is accepted, then discarded. There is no state change, no delay-line change, and no output.
- MAC: exactly `TAPS` cycles, one tap per cycle. acc += delay[ch][k] × coef[k] for k = 0..`TAPS`-1. The product is full-precision signed; the accumulator is `ACC_W` bits and cannot overflow. After the k = `TAPS`-1 cycle, the block moves to SCALE.
- SCALE: the block computes s = acc >>> shift (arithmetic shift), reduces s to `DATA_W` bits as set under Configuration, registers the result into `data_out` and `out_channel`, sets `out_valid`=1, and moves to OUT.
- OUT: `out_valid`, `data_out` and `out_channel` hold stable until `out_ready` is high. On that edge `out_valid` goes to 0 and the state returns to IDLE. `in_ready` is low throughout.
- Coefficient writes take effect only in IDLE; `coef_we` in any other state is ignored. If a write and a sample accept happen on the same IDLE edge, both take effect, and the new coefficient is used for that computation. A `coef_addr` ≥ `TAPS` is ignored.

## Timing
- `in_ready` is combinational from the state (IDLE).
- Latency: the accept happens on edge E0, `out_valid` rises after edge E0+`TAPS`+2, and the block is back in IDLE on the first edge where `out_ready` is high.
- Minimum sample period with `out_ready` tied high is `TAPS`+3 cycles.
- `out_ready` may be high before `out_valid`; that has no effect outside OUT.
- `rst_n` asserted mid-MAC or mid-OUT drops the computation at once; no result is ever emitted for it.

## Configuration
- `FIR_SATURATE_EN` defined: s is clamped to [-2^(`DATA_W`-1), 2^(`DATA_W`-1)-1].
- `FIR_SATURATE_EN` undefined: `data_out` = s[`DATA_W`-1:0], which wraps on overflow.
- Everything else is identical in both builds.

## Test plan
Bench parameters: `TAPS`=4, `CHANNELS`=2, defaults otherwise. Coefficients are loaded as coef[k] = k+1 unless stated.
- Impulse response: feed 1000 then 0, 0, 0, 0 on ch0 with shift 0 → outputs 1000, 2000, 3000, 4000, 0, each with `out_channel`=0. `out_valid` is exactly 6 edges after each accept.
- Channel isolation: after ch0 holds history from the impulse test, send 5 on ch1 → output 5 on `out_channel`=1. A following ch0 sample 0 continues ch0's sequence unaffected.
- Overflow: all coefficients = 32767, four ch0 samples of 32767, shift 0 → final output 32767 with `FIR_SATURATE_EN`, 4 without it. With shift 20, the output is 4095 in both builds.
- Backpressure: hold `out_ready` low for 10 cycles while in OUT → `out_valid`, `data_out` and `out_channel` stay constant, and `in_ready` stays 0. The block returns to IDLE the cycle after `out_ready` rises.
- Coefficient gating: `coef_we` to addr 0 with value 7 during MAC is ignored, so the impulse of 1000 still yields 1000. The same write in IDLE followed by the same impulse yields 7000.
- Reset mid-MAC: pull `rst_n` low 2 cycles after an accept → `out_valid`=0 and `data_out`=0 immediately. After release, an impulse of 1000 gives 0, because coefficients have reset to 0.
